// File: rtl/cis_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cis_frame_sequencer
// Description : Multi-row CIS/FE/ADC control-line sequencer driven by four
//               runtime-length bit-serial patterns with skip repetition.
// Revision    : 1.0 - initial release
// ============================================================================
module cis_frame_sequencer #(
    parameter int NUM_SIGNALS     = 10,
    parameter int MAX_PATTERN_LEN = 32,
    parameter int LEN_W           = $clog2(MAX_PATTERN_LEN)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [9:0]                                clk_div,
    input  logic                                      integration,
    input  logic                                      abort,
    input  logic [LEN_W-1:0]                          len_reset,
    input  logic [LEN_W-1:0]                          len_integ,
    input  logic [LEN_W-1:0]                          len_row,
    input  logic [LEN_W-1:0]                          len_skip,
    input  logic [15:0]                               num_rows,
    input  logic [15:0]                               skip_samples,
    input  logic [NUM_SIGNALS-1:0]                    pattern_idle,
    input  logic [NUM_SIGNALS-1:0][MAX_PATTERN_LEN-1:0] pattern_ccd_reset,
    input  logic [NUM_SIGNALS-1:0][MAX_PATTERN_LEN-1:0] pattern_integration,
    input  logic [NUM_SIGNALS-1:0][MAX_PATTERN_LEN-1:0] pattern_row,
    input  logic [NUM_SIGNALS-1:0][MAX_PATTERN_LEN-1:0] pattern_skipping,
    output logic [NUM_SIGNALS-1:0]                    signal,
    output logic                                      busy,
    output logic [2:0]                                phase,
    output logic [15:0]                               row_idx,
    output logic [15:0]                               skip_idx,
    output logic                                      row_done,
    output logic                                      frame_done
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CCD   = 3'd1;
    localparam logic [2:0] c_ST_INTEG = 3'd2;
    localparam logic [2:0] c_ST_ROW   = 3'd3;
    localparam logic [2:0] c_ST_SKIP  = 3'd4;

    // Selects bit idx of every signal's pattern to form one output column.
    function automatic logic [NUM_SIGNALS-1:0] f_col(
        input logic [NUM_SIGNALS-1:0][MAX_PATTERN_LEN-1:0] pat,
        input logic [LEN_W-1:0]                            idx
    );
        logic [NUM_SIGNALS-1:0] v;
        for (int s = 0; s < NUM_SIGNALS; s++) begin
            v[s] = pat[s][idx];
        end
        return v;
    endfunction

    logic [9:0]             r_div_cnt;
    logic                   r_tick;

    logic [LEN_W-1:0]       r_len_reset, r_len_integ, r_len_row, r_len_skip;
    logic [15:0]            r_num_rows, r_skip_samples;
    logic [NUM_SIGNALS-1:0][MAX_PATTERN_LEN-1:0] r_pat_ccd, r_pat_integ, r_pat_row, r_pat_skip;

    logic [2:0]             r_state, w_state;
    logic [LEN_W-1:0]       r_bit, w_bit;
    logic [LEN_W-1:0]       w_bit_dec;
    logic [NUM_SIGNALS-1:0] r_signal, w_signal;
    logic [15:0]            r_row_idx, w_row_idx;
    logic [15:0]            r_skip_idx, w_skip_idx;
    logic                   r_row_done, w_row_done;
    logic                   r_frame_done, w_frame_done;
    logic                   w_latch;

    // Free-running divider; a clk_div change is only compared against, so it lands at the next wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == clk_div) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 10'd1;
            r_tick    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_reset    <= '0;
            r_len_integ    <= '0;
            r_len_row      <= '0;
            r_len_skip     <= '0;
            r_num_rows     <= '0;
            r_skip_samples <= '0;
            r_pat_ccd      <= '0;
            r_pat_integ    <= '0;
            r_pat_row      <= '0;
            r_pat_skip     <= '0;
        end else if (w_latch) begin
            r_len_reset    <= len_reset;
            r_len_integ    <= len_integ;
            r_len_row      <= len_row;
            r_len_skip     <= len_skip;
            r_num_rows     <= num_rows;
            r_skip_samples <= skip_samples;
            r_pat_ccd      <= pattern_ccd_reset;
            r_pat_integ    <= pattern_integration;
            r_pat_row      <= pattern_row;
            r_pat_skip     <= pattern_skipping;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_bit        <= '0;
            r_signal     <= '0;
            r_row_idx    <= '0;
            r_skip_idx   <= '0;
            r_row_done   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_bit        <= w_bit;
            r_signal     <= w_signal;
            r_row_idx    <= w_row_idx;
            r_skip_idx   <= w_skip_idx;
            r_row_done   <= w_row_done;
            r_frame_done <= w_frame_done;
        end
    end

    assign w_bit_dec = r_bit - 1'b1;

    always_comb begin
        w_state      = r_state;
        w_bit        = r_bit;
        w_signal     = r_signal;
        w_row_idx    = r_row_idx;
        w_skip_idx   = r_skip_idx;
        w_row_done   = 1'b0;
        w_frame_done = 1'b0;
        w_latch      = 1'b0;

        if (abort) begin
            w_state    = c_ST_IDLE;
            w_signal   = pattern_idle;
            w_row_idx  = '0;
            w_skip_idx = '0;
        end else if (r_tick) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_signal = pattern_idle;
                    if (integration) begin
                        // Live inputs are used here because the latch only captures them this edge.
                        w_latch  = 1'b1;
                        w_state  = c_ST_CCD;
                        w_bit    = len_reset;
                        w_signal = f_col(pattern_ccd_reset, len_reset);
                    end
                end
                c_ST_CCD: begin
                    if (r_bit == '0) begin
                        w_state  = c_ST_INTEG;
                        w_bit    = r_len_integ;
                        w_signal = f_col(r_pat_integ, r_len_integ);
                    end else begin
                        w_bit    = w_bit_dec;
                        w_signal = f_col(r_pat_ccd, w_bit_dec);
                    end
                end
                c_ST_INTEG: begin
                    if (!integration) begin
                        if (r_bit == '0) begin
                            w_state   = c_ST_ROW;
                            w_row_idx = '0;
                            w_bit     = r_len_row;
                            w_signal  = f_col(r_pat_row, r_len_row);
                        end else begin
                            w_bit    = w_bit_dec;
                            w_signal = f_col(r_pat_integ, w_bit_dec);
                        end
                    end
                end
                c_ST_ROW: begin
                    if (r_bit == '0) begin
                        w_state    = c_ST_SKIP;
                        w_skip_idx = '0;
                        w_bit      = r_len_skip;
                        w_signal   = f_col(r_pat_skip, r_len_skip);
                    end else begin
                        w_bit    = w_bit_dec;
                        w_signal = f_col(r_pat_row, w_bit_dec);
                    end
                end
                c_ST_SKIP: begin
                    if (r_bit != '0) begin
                        w_bit    = w_bit_dec;
                        w_signal = f_col(r_pat_skip, w_bit_dec);
                    end else if (r_skip_idx < r_skip_samples) begin
                        w_skip_idx = r_skip_idx + 16'd1;
                        w_bit      = r_len_skip;
                        w_signal   = f_col(r_pat_skip, r_len_skip);
                    end else begin
                        w_row_done = 1'b1;
                        if (r_row_idx < r_num_rows) begin
                            w_row_idx = r_row_idx + 16'd1;
                            w_state   = c_ST_ROW;
                            w_bit     = r_len_row;
                            w_signal  = f_col(r_pat_row, r_len_row);
                        end else begin
                            w_state      = c_ST_IDLE;
                            w_signal     = pattern_idle;
                            w_frame_done = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state = c_ST_IDLE;
                end
            endcase
        end
    end

    assign signal     = r_signal;
    assign busy       = (r_state != c_ST_IDLE);
    assign phase      = r_state;
    assign row_idx    = r_row_idx;
    assign skip_idx   = r_skip_idx;
    assign row_done   = r_row_done;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_cis_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cis_frame_sequencer
// Description : Randomized bench for cis_frame_sequencer against a frame-level
//               reference model that expands each frame into a tick queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cis_frame_sequencer;

    localparam int NS = 10;
    localparam int ML = 32;
    localparam int LW = 5;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [9:0]             clk_div;
    logic                   integration;
    logic                   abort;
    logic [LW-1:0]          len_reset, len_integ, len_row, len_skip;
    logic [15:0]            num_rows, skip_samples;
    logic [NS-1:0]          pattern_idle;
    logic [NS-1:0][ML-1:0]  pattern_ccd_reset, pattern_integration, pattern_row, pattern_skipping;
    logic [NS-1:0]          signal;
    logic                   busy;
    logic [2:0]             phase;
    logic [15:0]            row_idx, skip_idx;
    logic                   row_done, frame_done;

    cis_frame_sequencer #(
        .NUM_SIGNALS    (NS),
        .MAX_PATTERN_LEN(ML),
        .LEN_W          (LW)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .clk_div            (clk_div),
        .integration        (integration),
        .abort              (abort),
        .len_reset          (len_reset),
        .len_integ          (len_integ),
        .len_row            (len_row),
        .len_skip           (len_skip),
        .num_rows           (num_rows),
        .skip_samples       (skip_samples),
        .pattern_idle       (pattern_idle),
        .pattern_ccd_reset  (pattern_ccd_reset),
        .pattern_integration(pattern_integration),
        .pattern_row        (pattern_row),
        .pattern_skipping   (pattern_skipping),
        .signal             (signal),
        .busy               (busy),
        .phase              (phase),
        .row_idx            (row_idx),
        .skip_idx           (skip_idx),
        .row_done           (row_done),
        .frame_done         (frame_done)
    );

    always #5 clk = ~clk;

    // One expected post-tick output tuple; ph uses the external phase numbering.
    typedef struct {
        logic [NS-1:0] sig;
        int            ph;
        int            row;
        int            skip;
        bit            rd;
        bit            fd;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    bit   exp_rd, exp_fd, chk_zero;
    int   n_cmp = 0, n_bad = 0;
    int   edge_n = 0;
    int   rd_cnt, fd_cnt, both_cnt;
    int   ph_clks[5];

    function automatic logic [NS-1:0] col(input logic [NS-1:0][ML-1:0] p, input int b);
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = p[s][b];
        return v;
    endfunction

    // Ticks fall every clk_div+1 clocks, the first on edge clk_div+2 after reset release.
    function automatic bit is_tick(input int n);
        int d;
        d = int'(clk_div);
        return (n >= d + 2) && (((n - (d + 2)) % (d + 1)) == 0);
    endfunction

    task automatic push(input logic [NS-1:0] s, input int ph, input int r, input int k, input bit rd, input bit fd);
        ent_t e;
        e.sig = s; e.ph = ph; e.row = r; e.skip = k; e.rd = rd; e.fd = fd;
        q.push_back(e);
    endtask

    // Expand a whole frame from the configuration present at frame start.
    task automatic build_frame();
        q.delete();
        for (int b = int'(len_reset); b >= 0; b--) push(col(pattern_ccd_reset, b), 1, 0, 0, 0, 0);
        for (int b = int'(len_integ); b >= 0; b--) push(col(pattern_integration, b), 2, 0, 0, 0, 0);
        for (int r = 0; r <= int'(num_rows); r++) begin
            for (int b = int'(len_row); b >= 0; b--)
                push(col(pattern_row, b), 3, r, 0, (r > 0) && (b == int'(len_row)), 0);
            for (int k = 0; k <= int'(skip_samples); k++)
                for (int b = int'(len_skip); b >= 0; b--)
                    push(col(pattern_skipping, b), 4, r, k, 0, 0);
        end
        push('0, 0, 0, 0, 1, 1);
    endtask

    task automatic pop();
        cur = q.pop_front();
        if (cur.ph == 0) cur.sig = pattern_idle;
        exp_rd   = cur.rd;
        exp_fd   = cur.fd;
        chk_zero = 1'b0;
    endtask

    // Advance the model one clk, clock the DUT, then score the sampled outputs.
    task automatic step();
        bit t;
        t = is_tick(edge_n + 1);
        exp_rd = 1'b0;
        exp_fd = 1'b0;
        if (abort) begin
            q.delete();
            cur.sig = pattern_idle; cur.ph = 0; cur.row = 0; cur.skip = 0;
            chk_zero = 1'b1;
        end else if (t) begin
            if (cur.ph == 2 && integration) begin
            end else if (q.size() > 0) begin
                pop();
            end else if (integration) begin
                build_frame();
                pop();
            end else begin
                cur.sig = pattern_idle;
                cur.ph  = 0;
            end
        end
        @(posedge clk);
        edge_n++;
        #1;
        rd_cnt   += int'(row_done);
        fd_cnt   += int'(frame_done);
        both_cnt += int'(row_done & frame_done);
        if (phase < 3'd5) ph_clks[phase]++;
        n_cmp++;
        if (signal !== cur.sig) begin
            n_bad++; $display("FAIL signal @edge %0d: got %h want %h", edge_n, signal, cur.sig);
        end
        n_cmp++;
        if (phase !== 3'(cur.ph)) begin
            n_bad++; $display("FAIL phase @edge %0d: got %0d want %0d", edge_n, phase, cur.ph);
        end
        n_cmp++;
        if (busy !== (cur.ph != 0)) begin
            n_bad++; $display("FAIL busy @edge %0d: got %b want %b", edge_n, busy, cur.ph != 0);
        end
        n_cmp++;
        if ({row_done, frame_done} !== {exp_rd, exp_fd}) begin
            n_bad++; $display("FAIL pulses @edge %0d: got rd=%b fd=%b want rd=%b fd=%b",
                              edge_n, row_done, frame_done, exp_rd, exp_fd);
        end
        if (cur.ph == 3 || cur.ph == 4) begin
            n_cmp++;
            if (row_idx !== 16'(cur.row)) begin
                n_bad++; $display("FAIL row_idx @edge %0d: got %0d want %0d", edge_n, row_idx, cur.row);
            end
        end
        if (cur.ph == 4) begin
            n_cmp++;
            if (skip_idx !== 16'(cur.skip)) begin
                n_bad++; $display("FAIL skip_idx @edge %0d: got %0d want %0d", edge_n, skip_idx, cur.skip);
            end
        end
        if (chk_zero) begin
            n_cmp++;
            if ({row_idx, skip_idx} !== 32'd0) begin
                n_bad++; $display("FAIL idx_cleared @edge %0d: got row %0d skip %0d want 0 0", edge_n, row_idx, skip_idx);
            end
        end
    endtask

    task automatic clear_counts();
        rd_cnt = 0; fd_cnt = 0; both_cnt = 0;
        for (int i = 0; i < 5; i++) ph_clks[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        edge_n = 0;
        q.delete();
        cur.sig = '0; cur.ph = 0; cur.row = 0; cur.skip = 0; cur.rd = 0; cur.fd = 0;
        chk_zero = 1'b1;
        clear_counts();
    endtask

    task automatic randomize_patterns();
        pattern_idle = NS'($urandom());
        for (int s = 0; s < NS; s++) begin
            pattern_ccd_reset[s]   = $urandom();
            pattern_integration[s] = $urandom();
            pattern_row[s]         = $urandom();
            pattern_skipping[s]    = $urandom();
        end
    endtask

    // Start a frame, keep integration high hold clks past frame start, run to IDLE.
    task automatic run_frame(input int hold, input int budget, input bit mutate);
        int k = 0;
        int h;
        integration = 1'b1;
        while (cur.ph == 0 && k < budget) begin step(); k++; end
        if (mutate) begin
            len_skip = len_skip + 5'd2;
            num_rows = num_rows + 16'd1;
            for (int s = 0; s < NS; s++) pattern_skipping[s] = $urandom();
        end
        h = hold;
        while (!(cur.ph == 0 && q.size() == 0) && k < budget) begin
            if (h > 0) h--; else integration = 1'b0;
            step(); k++;
        end
        integration = 1'b0;
        n_cmp++;
        if (k >= budget) begin
            n_bad++; $display("FAIL frame_timeout: ran %0d clks, required completion within %0d", k, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        n_cmp++;
        if ({signal, busy, phase, row_idx, skip_idx, row_done, frame_done} !== '0) begin
            n_bad++; $display("FAIL reset_state: got sig=%h busy=%b ph=%0d row=%0d skip=%0d rd=%b fd=%b want all 0",
                              signal, busy, phase, row_idx, skip_idx, row_done, frame_done);
        end
        do_reset();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_basic();
        logic [3:0] seq;
        int n = 0;
        clk_div = 10'd0;
        do_reset();
        randomize_patterns();
        len_reset = 5'd3; len_integ = 5'd0; len_row = 5'd0; len_skip = 5'd0;
        num_rows = 16'd0; skip_samples = 16'd0;
        pattern_ccd_reset[0][3:0] = 4'b1010;
        seq = '0;
        integration = 1'b1;
        while (cur.ph == 0 && n < 10) begin step(); n++; end
        integration = 1'b0;
        while (phase == 3'd1 && n < 20) begin
            seq = {seq[2:0], signal[0]};
            step(); n++;
        end
        run_frame(0, 50, 1'b0);
        n_cmp++;
        if (seq !== 4'b1010) begin
            n_bad++; $display("FAIL basic_sig0: got %b want 1010", seq);
        end
        n_cmp++;
        if ({ph_clks[2], ph_clks[3], ph_clks[4], fd_cnt} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
            n_bad++; $display("FAIL basic_timing: got integ=%0d row=%0d skip=%0d fd=%0d want 1 1 1 1",
                              ph_clks[2], ph_clks[3], ph_clks[4], fd_cnt);
        end
    endtask

    task automatic test_integ_hold();
        clk_div = 10'd2;
        do_reset();
        randomize_patterns();
        len_reset = 5'd1; len_integ = 5'd2; len_row = 5'd1; len_skip = 5'd0;
        num_rows = 16'd0; skip_samples = 16'd0;
        run_frame(20, 400, 1'b0);
        n_cmp++;
        if (ph_clks[1] !== 6) begin
            n_bad++; $display("FAIL integ_ccd_clks: got %0d want 6", ph_clks[1]);
        end
        n_cmp++;
        if (ph_clks[2] < 20) begin
            n_bad++; $display("FAIL integ_held_clks: got %0d want >= 20", ph_clks[2]);
        end
    endtask

    task automatic test_rows_skips();
        clk_div = 10'($urandom_range(0, 1));
        do_reset();
        randomize_patterns();
        len_reset = 5'($urandom_range(0, 3)); len_integ = 5'($urandom_range(0, 3));
        len_row = 5'($urandom_range(0, 3)); len_skip = 5'd1;
        num_rows = 16'd2; skip_samples = 16'd3;
        run_frame(0, 2000, 1'b0);
        n_cmp++;
        if (rd_cnt !== 3 || fd_cnt !== 1 || both_cnt !== 1) begin
            n_bad++; $display("FAIL rows_pulses: got rd=%0d fd=%0d coincide=%0d want 3 1 1", rd_cnt, fd_cnt, both_cnt);
        end
        n_cmp++;
        if (ph_clks[4] !== 12 * 2 * (int'(clk_div) + 1)) begin
            n_bad++; $display("FAIL rows_skip_clks: got %0d want %0d", ph_clks[4], 12 * 2 * (int'(clk_div) + 1));
        end
    endtask

    task automatic test_abort();
        int n = 0;
        clk_div = 10'd1;
        do_reset();
        randomize_patterns();
        len_reset = 5'd1; len_integ = 5'd0; len_row = 5'd1; len_skip = 5'd2;
        num_rows = 16'd1; skip_samples = 16'd2;
        integration = 1'b1;
        while (cur.ph == 0 && n < 20) begin step(); n++; end
        integration = 1'b0;
        while (!(cur.ph == 4 && cur.skip == 1 && is_tick(edge_n + 1)) && n < 200) begin step(); n++; end
        abort = 1'b1;
        step();
        abort = 1'b0;
        n_cmp++;
        if (phase !== 3'd0 || signal !== pattern_idle) begin
            n_bad++; $display("FAIL abort_idle: got ph=%0d sig=%h want 0 %h", phase, signal, pattern_idle);
        end
        clear_counts();
        for (int i = 0; i < 20; i++) step();
        n_cmp++;
        if (fd_cnt !== 0) begin
            n_bad++; $display("FAIL abort_no_frame_done: got %0d pulses want 0", fd_cnt);
        end
    endtask

    task automatic test_midframe_change();
        clk_div = 10'd0;
        do_reset();
        randomize_patterns();
        len_reset = 5'd0; len_integ = 5'd0; len_row = 5'd2; len_skip = 5'd1;
        num_rows = 16'd1; skip_samples = 16'd1;
        run_frame(0, 500, 1'b1);
        n_cmp++;
        if (rd_cnt !== 2 || ph_clks[4] !== 8) begin
            n_bad++; $display("FAIL midframe_latched: got rd=%0d skipclks=%0d want 2 8", rd_cnt, ph_clks[4]);
        end
        clear_counts();
        run_frame(0, 500, 1'b0);
        n_cmp++;
        if (rd_cnt !== 3 || ph_clks[4] !== 24) begin
            n_bad++; $display("FAIL midframe_next: got rd=%0d skipclks=%0d want 3 24", rd_cnt, ph_clks[4]);
        end
    endtask

    task automatic test_reset_mid_row();
        int n = 0;
        clk_div = 10'd1;
        do_reset();
        randomize_patterns();
        len_reset = 5'd0; len_integ = 5'd0; len_row = 5'd7; len_skip = 5'd0;
        num_rows = 16'd1; skip_samples = 16'd0;
        integration = 1'b1;
        while (cur.ph == 0 && n < 20) begin step(); n++; end
        integration = 1'b0;
        while (!(cur.ph == 3 && q.size() > 3) && n < 200) begin step(); n++; end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({signal, busy, phase, row_idx, skip_idx, row_done, frame_done} !== '0) begin
            n_bad++; $display("FAIL reset_mid_row: got sig=%h busy=%b ph=%0d row=%0d skip=%0d want all 0",
                              signal, busy, phase, row_idx, skip_idx);
        end
        do_reset();
        run_frame(0, 500, 1'b0);
        n_cmp++;
        if (fd_cnt !== 1 || rd_cnt !== 2) begin
            n_bad++; $display("FAIL reset_restart: got fd=%0d rd=%0d want 1 2", fd_cnt, rd_cnt);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            clk_div = 10'($urandom_range(0, 3));
            do_reset();
            randomize_patterns();
            len_reset = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            len_integ = 5'($urandom_range(0, 5));
            len_row   = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            len_skip  = 5'($urandom_range(0, 5));
            num_rows     = 16'($urandom_range(0, 2));
            skip_samples = 16'($urandom_range(0, 2));
            run_frame($urandom_range(0, 15), 20000, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; clk_div = 10'd0; integration = 1'b0; abort = 1'b0;
        len_reset = '0; len_integ = '0; len_row = '0; len_skip = '0;
        num_rows = '0; skip_samples = '0;
        randomize_patterns();
        cur.sig = '0; cur.ph = 0; cur.row = 0; cur.skip = 0; cur.rd = 0; cur.fd = 0;
        chk_zero = 1'b1; exp_rd = 1'b0; exp_fd = 1'b0;
        clear_counts();
        test_reset();
        test_basic();
        test_integ_hold();
        test_rows_skips();
        test_abort();
        test_midframe_change();
        test_reset_mid_row();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
